lexpander: RTL and testbench
============================

LEXPANDER -- requirements
Module: lexpander

Interface
REQ-001 SHALL have parameter W_TOTAL, default 16, total sample width (signed two's complement).
REQ-002 SHALL have parameter W_FRAC, default 15, fractional bits of sample and gain (Q1.15 data, U1.15 gain).
REQ-003 SHALL have parameter HOLD_W, default 16, width of hold counter and i_hold_samples.
REQ-004 SHALL have ports:
- i_clk  in  1  clock; single clock domain, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ce  in  1  input sample strobe; one sample per asserted cycle.
- i_data  in  W_TOTAL  signed input sample.
- i_threshold  in  W_TOTAL  unsigned magnitude threshold.
- i_attack_step  in  W_TOTAL  unsigned U1.15 gain increment per above-threshold sample.
- i_release_step  in  W_TOTAL  unsigned U1.15 gain decrement per released sample.
- i_hold_samples  in  HOLD_W  below-threshold samples held at unity before release.
- o_data  out  W_TOTAL  signed gated/expanded sample.
- o_ce  out  1  output strobe, one per accepted i_ce.

Function
REQ-005 SHALL implement a downward expander/noise gate: gain g (U1.15, range 0..0x8000) applied to each sample, steered by a 5-state FSM: CLOSED, ATTACK, OPEN, HOLD, RELEASE.
REQ-006 Stage 1 (on i_ce) SHALL register x1=i_data, above1=(|i_data| >= i_threshold), v1=1; |0x8000| saturates to 0x7FFF; v1=0 on cycles without i_ce.
REQ-007 Stage 2 (on v1) SHALL update FSM/g from above1, then register o_data=(x1*g_next)>>>W_FRAC (arithmetic shift, truncate toward minus infinity) and o_ce=1; o_ce=0 on all other cycles.
REQ-008 Latency SHALL be exactly 2 clocks from i_ce to o_ce; back-to-back i_ce SHALL give back-to-back o_ce.
REQ-009 Attack: g_next=min(g+attack,0x8000); release: g_next=max(g-release,0); a step input of 0 SHALL be treated as 0x8000 (instantaneous).
REQ-010 CLOSED: above -> attack step, ATTACK (OPEN if g_next=0x8000); below -> stay, g=0.
REQ-011 ATTACK: above -> attack step, OPEN when g_next=0x8000; below -> release step, RELEASE (CLOSED if g_next=0).
REQ-012 OPEN: above -> stay; below -> if i_hold_samples=0, release step and RELEASE, else HOLD with cnt=i_hold_samples-1, g unchanged.
REQ-013 HOLD: above -> OPEN, g unchanged; below -> if cnt=0, release step and RELEASE, else cnt=cnt-1.
REQ-014 RELEASE: above -> attack step, ATTACK (OPEN if 0x8000); below -> release step, CLOSED when g_next=0.
REQ-015 Control inputs SHALL be sampled on the stage in which they are used; mid-stream changes take effect on the next sample.
REQ-016 Product SHALL be computed at 2*W_TOTAL bits; since g<=1.0 the result SHALL never exceed |x1| and needs no saturation (0x8000*1.0=0x8000).

Reset
REQ-017 i_reset asserted SHALL immediately force o_data=0, o_ce=0, v1=0, x1=0, g=0, cnt=0, state CLOSED, independent of i_clk.
REQ-018 i_ce during reset SHALL be ignored; first sample accepted on the first rising edge with i_reset low.
REQ-019 Reset mid-operation SHALL discard in-flight samples (no o_ce for them).

Verification (i_threshold=0x1000, attack=0x4000, release=0x2000, hold=2 unless noted)
REQ-020 Assert i_reset -> o_data=0x0000, o_ce=0 before any clock edge.
REQ-021 From reset, single i_ce with 0x0800 -> o_ce exactly 2 clocks later, o_data=0x0000, state CLOSED.
REQ-022 Then three 0x2000 samples back-to-back -> o_data 0x1000, 0x2000, 0x2000 on consecutive cycles (g 0x4000, 0x8000, 0x8000; OPEN).
REQ-023 Then four 0x0800 samples -> o_data 0x0800, 0x0800, 0x0600, 0x0400 (hold 2, then g 0x6000, 0x4000).
REQ-024 From reset, attack=0, i_data=0x8000 -> o_data=0x8000, state OPEN after one sample.
REQ-025 Assert i_reset while OPEN with a sample in flight -> o_data=0, o_ce=0 immediately, no o_ce for that sample; next 0x0800 sample -> o_data=0x0000.

Source files
------------

// File: rtl/lexpander.sv
// Downward expander / noise gate: two-stage pipeline; a 5-state gain FSM
// ramps a U1.15 gain that multiplies each delayed sample.
module lexpander #(
  parameter int W_TOTAL = 16,
  parameter int W_FRAC  = 15,
  parameter int HOLD_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic signed [W_TOTAL-1:0] i_data,
  input  logic [W_TOTAL-1:0]        i_threshold,
  input  logic [W_TOTAL-1:0]        i_attack_step,
  input  logic [W_TOTAL-1:0]        i_release_step,
  input  logic [HOLD_W-1:0]         i_hold_samples,
  output logic signed [W_TOTAL-1:0] o_data,
  output logic                      o_ce
);
  // One extra bit lets the gain hold unity and absorb g + step without wrap.
  localparam int GW = W_TOTAL + 1;
  localparam logic [GW-1:0]     UNITY = GW'(1) << W_FRAC;
  localparam logic [HOLD_W-1:0] ONE_H = HOLD_W'(1);

  typedef enum logic [2:0] {S_CLOSED, S_ATTACK, S_OPEN, S_HOLD, S_RELEASE} state_t;

  logic signed [W_TOTAL-1:0] x1_q, x1_d;
  logic                      above1_q, above1_d, v1_q, v1_d;
  logic [W_TOTAL-1:0]        mag;
  state_t                    state_q, state_d;
  logic [GW-1:0]             g_q, g_d, g_up, g_dn, att, rel, sum_up;
  logic [HOLD_W-1:0]         cnt_q, cnt_d;
  logic signed [2*W_TOTAL-1:0] prod;
  logic signed [W_TOTAL-1:0] o_data_q, o_data_d;
  logic                      o_ce_q, o_ce_d;
  logic                      unused_prod;

  // Stage 1: capture sample and its threshold decision.
  always_comb begin
    if (i_data[W_TOTAL-1] && (i_data[W_TOTAL-2:0] == '0))
      mag = {1'b0, {(W_TOTAL-1){1'b1}}};
    else if (i_data[W_TOTAL-1])
      mag = $unsigned(-i_data);
    else
      mag = $unsigned(i_data);
    v1_d     = i_ce;
    x1_d     = i_ce ? i_data : x1_q;
    above1_d = i_ce ? (mag >= i_threshold) : above1_q;
  end

  // Stage 2: gain steps; a zero step means jump straight to the limit.
  always_comb begin
    att    = (i_attack_step  == '0) ? UNITY : {1'b0, i_attack_step};
    rel    = (i_release_step == '0) ? UNITY : {1'b0, i_release_step};
    sum_up = g_q + att;
    g_up   = (sum_up >= UNITY) ? UNITY : sum_up;
    g_dn   = (rel >= g_q) ? '0 : g_q - rel;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    if (v1_q) begin
      unique case (state_q)
        S_CLOSED:
          if (above1_q) begin
            g_d     = g_up;
            state_d = (g_up == UNITY) ? S_OPEN : S_ATTACK;
          end else begin
            g_d = '0;
          end
        S_ATTACK:
          if (above1_q) begin
            g_d     = g_up;
            state_d = (g_up == UNITY) ? S_OPEN : S_ATTACK;
          end else begin
            g_d     = g_dn;
            state_d = (g_dn == '0) ? S_CLOSED : S_RELEASE;
          end
        S_OPEN:
          if (!above1_q) begin
            if (i_hold_samples == '0) begin
              g_d     = g_dn;
              state_d = S_RELEASE;
            end else begin
              cnt_d   = i_hold_samples - ONE_H;
              state_d = S_HOLD;
            end
          end
        S_HOLD:
          if (above1_q) begin
            state_d = S_OPEN;
          end else if (cnt_q == '0) begin
            g_d     = g_dn;
            state_d = S_RELEASE;
          end else begin
            cnt_d = cnt_q - ONE_H;
          end
        S_RELEASE:
          if (above1_q) begin
            g_d     = g_up;
            state_d = (g_up == UNITY) ? S_OPEN : S_ATTACK;
          end else begin
            g_d = g_dn;
            if (g_dn == '0) state_d = S_CLOSED;
          end
        default: begin
          state_d = S_CLOSED;
          g_d     = '0;
        end
      endcase
    end
  end

  // g <= 1.0 so the shifted product always fits; the slice is the >>> result.
  always_comb begin
    prod     = $signed({{W_TOTAL{x1_q[W_TOTAL-1]}}, x1_q}) *
               $signed({{(W_TOTAL-1){1'b0}}, g_d});
    o_ce_d   = v1_q;
    o_data_d = v1_q ? prod[W_FRAC +: W_TOTAL] : o_data_q;
  end

  assign unused_prod = ^{prod[W_FRAC-1:0], prod[2*W_TOTAL-1:W_FRAC+W_TOTAL]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x1_q     <= '0;
      above1_q <= 1'b0;
      v1_q     <= 1'b0;
      state_q  <= S_CLOSED;
      g_q      <= '0;
      cnt_q    <= '0;
      o_data_q <= '0;
      o_ce_q   <= 1'b0;
    end else begin
      x1_q     <= x1_d;
      above1_q <= above1_d;
      v1_q     <= v1_d;
      state_q  <= state_d;
      g_q      <= g_d;
      cnt_q    <= cnt_d;
      o_data_q <= o_data_d;
      o_ce_q   <= o_ce_d;
    end
  end

  assign o_data = o_data_q;
  assign o_ce   = o_ce_q;
endmodule

// File: tb/tb_lexpander.sv
// Bench for lexpander: directed literal sequences plus randomized traffic
// checked every cycle against a sample-level behavioural gate model.
module tb_lexpander;
  localparam int CL = 0, AT = 1, OP = 2, HD = 3, RL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] data = '0, thr = 16'h1000, att = 16'h4000, rel = 16'h2000, hold = 16'd2;
  logic [15:0] o_data;
  logic        o_ce;

  int n_chk = 0, n_fail = 0;
  logic [15:0] outs[$];

  // model state
  int   m_st = CL, m_g = 0, m_cnt = 0, p_x = 0, prod = 0, mag = 0;
  bit   p_v = 1'b0, p_above = 1'b0, e_ce = 1'b0;
  logic [15:0] e_data = '0;

  always #5 clk = ~clk;

  lexpander #(.W_TOTAL(16), .W_FRAC(15), .HOLD_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(data),
    .i_threshold(thr), .i_attack_step(att), .i_release_step(rel),
    .i_hold_samples(hold), .o_data(o_data), .o_ce(o_ce)
  );

  task automatic gate(input bit above);
    int a, r, up, dn;
    a  = (att == 16'h0) ? 32768 : int'(att);
    r  = (rel == 16'h0) ? 32768 : int'(rel);
    up = (m_g + a > 32768) ? 32768 : m_g + a;
    dn = (m_g - r < 0) ? 0 : m_g - r;
    case (m_st)
      CL: if (above) begin m_g = up; m_st = (up == 32768) ? OP : AT; end
          else m_g = 0;
      AT: if (above) begin m_g = up; m_st = (up == 32768) ? OP : AT; end
          else begin m_g = dn; m_st = (dn == 0) ? CL : RL; end
      OP: if (!above) begin
            if (hold == 16'h0) begin m_g = dn; m_st = RL; end
            else begin m_cnt = int'(hold) - 1; m_st = HD; end
          end
      HD: if (above) m_st = OP;
          else if (m_cnt == 0) begin m_g = dn; m_st = RL; end
          else m_cnt = m_cnt - 1;
      RL: if (above) begin m_g = up; m_st = (up == 32768) ? OP : AT; end
          else begin m_g = dn; if (dn == 0) m_st = CL; end
      default: ;
    endcase
  endtask

  // Sample-level reference: result of the sample accepted one edge earlier.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = CL; m_g = 0; m_cnt = 0; p_v = 1'b0; p_x = 0; p_above = 1'b0;
      e_ce = 1'b0; e_data = '0;
    end else begin
      e_ce = p_v;
      if (p_v) begin
        gate(p_above);
        prod   = (p_x * m_g) >>> 15;
        e_data = prod[15:0];
      end
      p_v = ce;
      if (ce) begin
        p_x = $signed(data);
        mag = (p_x < 0) ? -p_x : p_x;
        if (mag > 32767) mag = 32767;
        p_above = (mag >= int'(thr));
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("o_ce", {15'b0, o_ce}, {15'b0, e_ce});
        if (e_ce) check("o_data", o_data, e_data);
        if (o_ce) outs.push_back(o_data);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_lit(input string nm, input logic [15:0] xs[$], input logic [15:0] ex[$]);
    outs.delete();
    foreach (xs[i]) begin ce = 1'b1; data = xs[i]; cyc(1); end
    ce = 1'b0;
    cyc(3);
    check({nm, "_count"}, 16'(outs.size()), 16'(ex.size()));
    foreach (ex[i]) if (i < outs.size()) check(nm, outs[i], ex[i]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; #1;
    check("rst_now_o_ce", {15'b0, o_ce}, 16'h0);
    check("rst_now_o_data", o_data, 16'h0);
    ce = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] xs[$], ex[$];
    fork monitor(); join_none
    #1 rst = 1'b1; #1;
    check("reset_o_data", o_data, 16'h0000);
    check("reset_o_ce", {15'b0, o_ce}, 16'h0);
    @(posedge clk); #1 ce = 1'b1; data = 16'h2000;  // ignored while in reset
    @(posedge clk); #1 ce = 1'b0; rst = 1'b0;

    // single below-threshold sample: output exactly two edges later
    ce = 1'b1; data = 16'h0800; cyc(1); ce = 1'b0;
    check("lat_edge1_o_ce", {15'b0, o_ce}, 16'h0);
    cyc(1);
    check("lat_edge2_o_ce", {15'b0, o_ce}, 16'h1);
    check("lat_edge2_o_data", o_data, 16'h0000);
    cyc(1);
    check("lat_edge3_o_ce", {15'b0, o_ce}, 16'h0);

    xs = {16'h2000, 16'h2000, 16'h2000};
    ex = {16'h1000, 16'h2000, 16'h2000};
    run_lit("attack_seq", xs, ex);
    xs = {16'h0800, 16'h0800, 16'h0800, 16'h0800};
    ex = {16'h0800, 16'h0800, 16'h0600, 16'h0400};
    run_lit("hold_release_seq", xs, ex);

    // instantaneous attack with full-scale negative input
    pulse_reset();
    att = 16'h0000;
    xs = {16'h8000}; ex = {16'h8000};
    run_lit("instant_attack", xs, ex);
    xs = {16'h2000}; ex = {16'h2000};
    run_lit("open_unity", xs, ex);

    // reset while open with one sample in flight
    ce = 1'b1; data = 16'h2000; cyc(1);
    cyc(1); ce = 1'b0;
    #1 rst = 1'b1; #1;
    check("midrst_o_data", o_data, 16'h0000);
    check("midrst_o_ce", {15'b0, o_ce}, 16'h0);
    outs.delete();
    @(posedge clk); #1 rst = 1'b0;
    cyc(3);
    check("midrst_dropped", 16'(outs.size()), 16'h0);
    att = 16'h4000;
    xs = {16'h0800}; ex = {16'h0000};
    run_lit("after_reset", xs, ex);

    // randomized traffic with mid-stream control changes and reset pulses
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        thr  = 16'($urandom_range(0, 16'h2000));
        att  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h9000));
        rel  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h9000));
        hold = 16'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 399) == 0) pulse_reset();
      ce = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: data = 16'h8000;
        1: data = 16'($urandom);
        default: begin
          data = 16'($urandom_range(0, 16'h1800));
          if ($urandom_range(0, 1) == 1) data = -data;
        end
      endcase
      cyc(1);
    end
    ce = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
